// File: rtl/activate_diff_pkg.sv
// Shared defaults and bundle-width helper for the activate/diff pipeline buffer.
package activate_diff_pkg;

    localparam int DEF_SIZE                   = 3;
    localparam int DEF_DATA_SIZE              = 16;
    localparam int DEF_COST_TYPE_SIZE         = 8;
    localparam int DEF_DENSE_TYPE_SIZE        = 4;
    localparam int DEF_BACKPROP_CONTROLL_SIZE = 100;
    localparam int DEF_DEPTH                  = 2;

    // Width of one stored entry: four vector buses plus the three control fields.
    function automatic int bundle_width(
        input int size,
        input int data_size,
        input int cost_w,
        input int dense_w,
        input int bp_w
    );
        return 4 * data_size * size + cost_w + dense_w + bp_w;
    endfunction

endpackage

// File: rtl/activate_diff_fifo_mem.sv
// Storage, pointers and occupancy count for the activate/diff pipeline buffer.
// The head entry is presented combinationally; when the buffer is empty the
// last presented value is held so downstream sees stable data.
module activate_diff_fifo_mem
    import activate_diff_pkg::*;
#(
    parameter int WIDTH = 352,
    parameter int DEPTH = DEF_DEPTH,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] hold_q;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Head entry when occupied, otherwise the last value shown.
    assign rd_data = (count != '0) ? mem[rd_ptr] : hold_q;

    // Pointer, count and storage update; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Remember what was last presented so the outputs hold while empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= rd_data;
        end
    end

endmodule

// File: rtl/activate_diff_pipe.sv
// Elastic buffer for activate/diff bundles with valid/ready on both sides.
// Packs the seven input fields into one entry, unpacks the head entry.
// Optional stall counter enabled by defining ACTIVATE_DIFF_PIPE_STATS_EN.
module activate_diff_pipe
    import activate_diff_pkg::*;
#(
    parameter int size                   = DEF_SIZE,
    parameter int data_size              = DEF_DATA_SIZE,
    parameter int cost_type_size         = DEF_COST_TYPE_SIZE,
    parameter int dense_type_size        = DEF_DENSE_TYPE_SIZE,
    parameter int backprop_controll_size = DEF_BACKPROP_CONTROLL_SIZE,
    parameter int DEPTH                  = DEF_DEPTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [data_size*size-1:0]         predict_value,
    input  logic [data_size*size-1:0]         w,
    input  logic [data_size*size-1:0]         x,
    input  logic [data_size*size-1:0]         z,
    input  logic [cost_type_size-1:0]         cost_type,
    input  logic [dense_type_size-1:0]        dense_type,
    input  logic [backprop_controll_size-1:0] backprop_controll,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [data_size*size-1:0]         predict_value_out,
    output logic [data_size*size-1:0]         w_out,
    output logic [data_size*size-1:0]         x_out,
    output logic [data_size*size-1:0]         z_out,
    output logic [cost_type_size-1:0]         cost_type_out,
    output logic [dense_type_size-1:0]        dense_type_out,
    output logic [backprop_controll_size-1:0] backprop_controll_out,
    output logic [$clog2(DEPTH+1)-1:0]        count
`ifdef ACTIVATE_DIFF_PIPE_STATS_EN
    ,
    output logic [31:0]                       stall_cycles
`endif
);

    localparam int VEC_W    = data_size * size;
    localparam int BUNDLE_W = bundle_width(size, data_size, cost_type_size,
                                           dense_type_size, backprop_controll_size);
    localparam int CNT_W    = $clog2(DEPTH + 1);

    localparam int OFS_BP    = 0;
    localparam int OFS_DENSE = OFS_BP + backprop_controll_size;
    localparam int OFS_COST  = OFS_DENSE + dense_type_size;
    localparam int OFS_Z     = OFS_COST + cost_type_size;
    localparam int OFS_X     = OFS_Z + VEC_W;
    localparam int OFS_W     = OFS_X + VEC_W;
    localparam int OFS_PV    = OFS_W + VEC_W;

    logic [BUNDLE_W-1:0] wr_bundle;
    logic [BUNDLE_W-1:0] rd_bundle;
    logic                push;
    logic                pop;

    // Handshake flags depend only on the registered count.
    assign in_ready  = (count < CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign wr_bundle = {predict_value, w, x, z, cost_type, dense_type, backprop_controll};

    activate_diff_fifo_mem #(
        .WIDTH (BUNDLE_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_bundle),
        .rd_data (rd_bundle),
        .count   (count)
    );

    assign predict_value_out     = rd_bundle[OFS_PV    +: VEC_W];
    assign w_out                 = rd_bundle[OFS_W     +: VEC_W];
    assign x_out                 = rd_bundle[OFS_X     +: VEC_W];
    assign z_out                 = rd_bundle[OFS_Z     +: VEC_W];
    assign cost_type_out         = rd_bundle[OFS_COST  +: cost_type_size];
    assign dense_type_out        = rd_bundle[OFS_DENSE +: dense_type_size];
    assign backprop_controll_out = rd_bundle[OFS_BP    +: backprop_controll_size];

`ifdef ACTIVATE_DIFF_PIPE_STATS_EN
    // Count edges where data waits on downstream, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_activate_diff_pipe.sv
// Directed self-checking bench for activate_diff_pipe (DEPTH=2 and DEPTH=3).
// Stall-counter checks compile in when ACTIVATE_DIFF_PIPE_STATS_EN is defined.
module tb_activate_diff_pipe;

    logic         clk;
    logic         reset;
    logic         flush;
    logic [47:0]  predict_value;
    logic [47:0]  w;
    logic [47:0]  x;
    logic [47:0]  z;
    logic [7:0]   cost_type;
    logic [3:0]   dense_type;
    logic [99:0]  backprop_controll;

    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [47:0]  a_pv_out, a_w_out, a_x_out, a_z_out;
    logic [7:0]   a_cost_out;
    logic [3:0]   a_dense_out;
    logic [99:0]  a_bp_out;
    logic [1:0]   a_count;

    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [47:0]  b_pv_out, b_w_out, b_x_out, b_z_out;
    logic [7:0]   b_cost_out;
    logic [3:0]   b_dense_out;
    logic [99:0]  b_bp_out;
    logic [1:0]   b_count;

`ifdef ACTIVATE_DIFF_PIPE_STATS_EN
    logic [31:0]  a_stall, b_stall;
`endif

    int errors = 0;
    int checks = 0;

    activate_diff_pipe #(.DEPTH(2)) dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .predict_value(predict_value), .w(w), .x(x), .z(z),
        .cost_type(cost_type), .dense_type(dense_type), .backprop_controll(backprop_controll),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .predict_value_out(a_pv_out), .w_out(a_w_out), .x_out(a_x_out), .z_out(a_z_out),
        .cost_type_out(a_cost_out), .dense_type_out(a_dense_out),
        .backprop_controll_out(a_bp_out), .count(a_count)
`ifdef ACTIVATE_DIFF_PIPE_STATS_EN
        , .stall_cycles(a_stall)
`endif
    );

    activate_diff_pipe #(.DEPTH(3)) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .predict_value(predict_value), .w(w), .x(x), .z(z),
        .cost_type(cost_type), .dense_type(dense_type), .backprop_controll(backprop_controll),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .predict_value_out(b_pv_out), .w_out(b_w_out), .x_out(b_x_out), .z_out(b_z_out),
        .cost_type_out(b_cost_out), .dense_type_out(b_dense_out),
        .backprop_controll_out(b_bp_out), .count(b_count)
`ifdef ACTIVATE_DIFF_PIPE_STATS_EN
        , .stall_cycles(b_stall)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the DEPTH=2 handshake plus the z lane-0 and cost_type fields.
    task automatic applyStimulus(input logic iv, input logic ordy,
                                 input logic [15:0] zval, input logic [7:0] cval);
        a_in_valid  = iv;
        a_out_ready = ordy;
        z           = {32'h0, zval};
        cost_type   = cval;
    endtask

    // One comparison: count it, and report any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Wrap-test table for DEPTH=3: inputs per edge and expected state after it.
    logic        wr_iv   [12] = '{1,1,1,0,1,1,0,1,1,0,0,0};
    logic        wr_or   [12] = '{0,0,0,1,1,1,1,0,0,1,1,1};
    logic [15:0] wr_dat  [12] = '{16'hA0,16'hA1,16'hA2,16'h0,16'hA3,16'hA4,
                                  16'h0,16'hA5,16'hA6,16'h0,16'h0,16'h0};
    logic [1:0]  wr_cnt  [12] = '{1,2,3,2,2,2,1,2,3,2,1,0};
    logic [15:0] wr_head [12] = '{16'hA0,16'hA0,16'hA0,16'hA1,16'hA2,16'hA3,
                                  16'hA4,16'hA4,16'hA4,16'hA5,16'hA6,16'hA6};

    // Linear directed sequence.
    initial begin
        reset             = 1'b1;
        flush             = 1'b0;
        predict_value     = 48'hAAAA_5555_AAAA;
        w                 = 48'h1234_5678_9ABC;
        x                 = 48'h0F0F_F0F0_0F0F;
        dense_type        = 4'h5;
        backprop_controll = 100'h1_2345_6789_ABCD_EF01_2345_6789;
        b_in_valid        = 1'b0;
        b_out_ready       = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0, 8'h0);

        // Reset held for two edges.
        repeat (2) tick();
        reset = 1'b0;
        checkOutput("rst_out_valid", 32'(a_out_valid), 32'd0);
        checkOutput("rst_in_ready",  32'(a_in_ready),  32'd1);
        checkOutput("rst_count",     32'(a_count),     32'd0);
        checkOutput("rst_z_out",     a_z_out[31:0],    32'd0);
        checkOutput("rst_cost_out",  32'(a_cost_out),  32'd0);
        checkOutput("rst_pv_zero",   32'(a_pv_out == 48'h0), 32'd1);
        checkOutput("rst_bp_zero",   32'(a_bp_out == 100'h0), 32'd1);
        checkOutput("rst_b_count",   32'(b_count),     32'd0);

        // Fill to full, third push dropped, then drain in order.
        applyStimulus(1'b1, 1'b0, 16'h0001, 8'h11);
        tick();
        checkOutput("fill_count1",   32'(a_count),     32'd1);
        checkOutput("fill_valid1",   32'(a_out_valid), 32'd1);
        checkOutput("fill_head1",    32'(a_z_out[15:0]), 32'h0001);
        checkOutput("fill_w_out",    a_w_out[31:0],    32'h5678_9ABC);
        checkOutput("fill_pv_out",   a_pv_out[31:0],   32'h5555_AAAA);
        checkOutput("fill_dense",    32'(a_dense_out), 32'h5);
        checkOutput("fill_bp_low",   a_bp_out[31:0],   32'h2345_6789);
        checkOutput("fill_cost",     32'(a_cost_out),  32'h11);
        applyStimulus(1'b1, 1'b0, 16'h0002, 8'h12);
        tick();
        checkOutput("fill_count2",   32'(a_count),     32'd2);
        checkOutput("fill_ready_full", 32'(a_in_ready), 32'd0);
        checkOutput("fill_head_stable", 32'(a_z_out[15:0]), 32'h0001);
        applyStimulus(1'b1, 1'b0, 16'h0003, 8'h13);
        tick();
        checkOutput("full_drop_count", 32'(a_count),   32'd2);
        checkOutput("full_drop_head",  32'(a_z_out[15:0]), 32'h0001);
        applyStimulus(1'b0, 1'b1, 16'h0000, 8'h00);
        tick();
        checkOutput("pop1_head",     32'(a_z_out[15:0]), 32'h0002);
        checkOutput("pop1_count",    32'(a_count),     32'd1);
        tick();
        checkOutput("pop2_count",    32'(a_count),     32'd0);
        checkOutput("pop2_valid",    32'(a_out_valid), 32'd0);
        checkOutput("empty_hold_z",  32'(a_z_out[15:0]), 32'h0002);
        tick();
        checkOutput("underflow_count", 32'(a_count),   32'd0);

        // Streaming: push and pop every edge, one-cycle latency.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 16'h0, 8'(i));
            tick();
            checkOutput("stream_cost",  32'(a_cost_out), 32'(i));
            checkOutput("stream_count", 32'(a_count),    32'd1);
        end
        applyStimulus(1'b0, 1'b1, 16'h0, 8'h00);
        tick();
        checkOutput("stream_drain",  32'(a_count),     32'd0);

        // Flush while full, with push and pop requested in the same cycle.
        applyStimulus(1'b1, 1'b0, 16'h0010, 8'h00);
        tick();
        applyStimulus(1'b1, 1'b0, 16'h0011, 8'h00);
        tick();
        checkOutput("pre_flush_count", 32'(a_count),   32'd2);
        applyStimulus(1'b1, 1'b1, 16'h0012, 8'h00);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush_count",   32'(a_count),     32'd0);
        checkOutput("flush_valid",   32'(a_out_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 16'h0020, 8'h00);
        tick();
        checkOutput("post_flush_count", 32'(a_count),  32'd1);
        checkOutput("post_flush_head",  32'(a_z_out[15:0]), 32'h0020);
        // Flush also beats an accepted push when there is room.
        applyStimulus(1'b1, 1'b0, 16'h0021, 8'h00);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush_push_count", 32'(a_count),  32'd0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);

        // Pointer wrap on the DEPTH=3 instance.
        for (int i = 0; i < 12; i++) begin
            b_in_valid  = wr_iv[i];
            b_out_ready = wr_or[i];
            z           = {32'h0, wr_dat[i]};
            tick();
            checkOutput("wrap_count", 32'(b_count), 32'(wr_cnt[i]));
            if (wr_cnt[i] != 2'd0) begin
                checkOutput("wrap_head", 32'(b_z_out[15:0]), 32'(wr_head[i]));
            end
            if (i == 2) begin
                checkOutput("wrap_full_ready", 32'(b_in_ready), 32'd0);
            end
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;

        // Reset in the middle of holding data drops everything.
        applyStimulus(1'b1, 1'b0, 16'h0030, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midreset_count", 32'(a_count),   32'd0);
        checkOutput("midreset_z",     a_z_out[31:0],  32'd0);

`ifdef ACTIVATE_DIFF_PIPE_STATS_EN
        // Stall counter: one held entry, downstream not ready for five edges.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        applyStimulus(1'b1, 1'b0, 16'h0055, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
        checkOutput("stall_start", a_stall, 32'd0);
        repeat (5) tick();
        checkOutput("stall_five", a_stall, 32'd5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("stall_flush", a_stall, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
